// File: rtl/cpu_ma.sv
// -----------------------------------------------------------------------------
// cpu_ma -- RISC-V memory-access pipeline stage
//
// Consumes the EX->MA pipeline register, performs at most one data-memory
// access per instruction over a req/ack port, and registers the result
// toward WB. Also drives combinational forwarding and a stall toward the
// upstream stages.
//
// Handshake (dmem port): dmem_req_o is registered and, once raised, it and
// dmem_addr_o/dmem_we_o/dmem_wmask_o/dmem_wdata_o stay constant until the
// memory answers with a single-cycle dmem_ack_i (dmem_rdata_i valid in that
// same cycle). dmem_ack_i outside BUSY is ignored. Upstream must hold every
// *_i input stable while stall_async_o is high.
//
// Input encodings:
//   ma_mode_i : 0 = MA_X (no access), 1 = MA_LOAD, 2 = MA_STORE, 3 = no access
//   ma_size_i : 0 = B, 1 = H, 2 = W, 4 = BU, 5 = HU (bit 2 = zero-extend)
//   wb_src_i  : 1 = WB_SRC_MEM, every other code is a non-memory source
//
// Ports:
//   clk_i, reset_i           clock, asynchronous active-high reset
//   pc_i, ir_i               instruction identity from EX
//   ma_addr_i/mode/size/data access description and store data
//   wb_src_i/data_i/valid_i  write-back source, non-memory data, valid
//   dmem_*                   data-memory request port
//   wb_*_async_o             combinational forwarding toward EX/ID
//   empty_async_o            stage holds a NOP and no access is in flight
//   stall_async_o            hold upstream inputs stable
//   pc_o, ir_o, wb_data_o, wb_valid_o   registered results toward WB
//   trap_o, trap_cause_o     one-cycle trap pulse; cause 0 misaligned, 1 timeout
//   dbg_state_o              current FSM state (0 IDLE, 1 BUSY)
// -----------------------------------------------------------------------------
module cpu_ma #(
    parameter int unsigned DMEM_TIMEOUT = 0,
    parameter logic [31:0] NOP_PC       = 32'h0000_0000,
    parameter logic [31:0] NOP_IR       = 32'h0000_0013,
    parameter logic        NOP_WB_VALID = 1'b0
) (
    input  logic        clk_i,
    input  logic        reset_i,

    input  logic [31:0] pc_i,
    input  logic [31:0] ir_i,
    input  logic [31:0] ma_addr_i,
    input  logic [1:0]  ma_mode_i,
    input  logic [2:0]  ma_size_i,
    input  logic [31:0] ma_data_i,
    input  logic [1:0]  wb_src_i,
    input  logic [31:0] wb_data_i,
    input  logic        wb_valid_i,

    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_wmask_o,
    output logic [31:0] dmem_wdata_o,
    input  logic [31:0] dmem_rdata_i,
    input  logic        dmem_ack_i,

    output logic [4:0]  wb_addr_async_o,
    output logic [31:0] wb_data_async_o,
    output logic        wb_ready_async_o,
    output logic        wb_valid_async_o,
    output logic        empty_async_o,
    output logic        stall_async_o,

    output logic [31:0] pc_o,
    output logic [31:0] ir_o,
    output logic [31:0] wb_data_o,
    output logic        wb_valid_o,
    output logic        trap_o,
    output logic        trap_cause_o,

    output logic        dbg_state_o
);

    localparam logic [1:0] MA_LOAD    = 2'd1;
    localparam logic [1:0] MA_STORE   = 2'd2;
    localparam logic [1:0] SZ_B       = 2'd0;
    localparam logic [1:0] SZ_H       = 2'd1;
    localparam logic [1:0] WB_SRC_MEM = 2'd1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t      state_q;
    logic [31:0] tmo_cnt_q;

    // ------------------------------------------------------------------
    // Access decode
    // ------------------------------------------------------------------
    logic        is_load;
    logic        is_store;
    logic        mem_op;
    logic        misaligned;
    logic        busy;
    logic [1:0]  off;
    logic [3:0]  wmask_d;
    logic [31:0] wdata_d;
    logic [31:0] rshift;
    logic [31:0] ld_data_d;
    logic [31:0] tmo_cnt_d;
    logic        tmo_fire;

    always_comb begin
        is_load  = (ma_mode_i == MA_LOAD);
        is_store = (ma_mode_i == MA_STORE);
        mem_op   = is_load || is_store;
        busy     = (state_q == S_BUSY);
        off      = ma_addr_i[1:0];

        // Size code 3 is undefined and behaves as a word access.
        case (ma_size_i[1:0])
            SZ_B:    misaligned = 1'b0;
            SZ_H:    misaligned = off[0];
            default: misaligned = (off != 2'b00);
        endcase
    end

    // Store lane steering: data is replicated across the word so the
    // write mask alone selects which lanes land in memory.
    always_comb begin
        case (ma_size_i[1:0])
            SZ_B: begin
                wmask_d = 4'b0001 << off;
                wdata_d = {4{ma_data_i[7:0]}};
            end
            SZ_H: begin
                wmask_d = 4'b0011 << off;
                wdata_d = {2{ma_data_i[15:0]}};
            end
            default: begin
                wmask_d = 4'b1111;
                wdata_d = ma_data_i;
            end
        endcase
    end

    // Load formatting: bring the addressed byte/half down to bit 0, then
    // extend. Word loads are always aligned, so the shift is zero there.
    always_comb begin
        rshift = dmem_rdata_i >> {off, 3'b000};
        case (ma_size_i[1:0])
            SZ_B:    ld_data_d = {{24{rshift[7]  & ~ma_size_i[2]}}, rshift[7:0]};
            SZ_H:    ld_data_d = {{16{rshift[15] & ~ma_size_i[2]}}, rshift[15:0]};
            default: ld_data_d = rshift;
        endcase
    end

    // Timeout fires in the BUSY cycle whose wait would bring the count of
    // ack-less BUSY cycles up to DMEM_TIMEOUT.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q + 32'd1;
        tmo_fire  = (DMEM_TIMEOUT != 0) && busy && !dmem_ack_i &&
                    (tmo_cnt_d == DMEM_TIMEOUT);
    end

    // ------------------------------------------------------------------
    // Forwarding and stall
    // ------------------------------------------------------------------
    always_comb begin
        wb_addr_async_o  = ir_i[11:7];
        wb_valid_async_o = wb_valid_i;
        wb_data_async_o  = (busy && dmem_ack_i && is_load) ? ld_data_d : wb_data_i;
        wb_ready_async_o = (wb_src_i != WB_SRC_MEM) || (busy && dmem_ack_i);
        empty_async_o    = (pc_i == NOP_PC) && !busy;
        dbg_state_o      = state_q;

        // The stall also drops in the aborting cycle so the trapped
        // instruction leaves the stage instead of being re-issued.
        if (busy)
            stall_async_o = !dmem_ack_i && !tmo_fire;
        else
            stall_async_o = mem_op && !misaligned;
    end

    // ------------------------------------------------------------------
    // FSM and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            tmo_cnt_q    <= '0;
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= '0;
            dmem_wmask_o <= '0;
            dmem_wdata_o <= '0;
            pc_o         <= NOP_PC;
            ir_o         <= NOP_IR;
            wb_data_o    <= '0;
            wb_valid_o   <= NOP_WB_VALID;
            trap_o       <= 1'b0;
            trap_cause_o <= 1'b0;
        end else begin
            trap_o <= 1'b0;

            if (state_q == S_IDLE) begin
                tmo_cnt_q <= '0;
                if (mem_op && !misaligned) begin
                    // Launch the access; WB sees a bubble until it completes.
                    state_q      <= S_BUSY;
                    dmem_req_o   <= 1'b1;
                    dmem_we_o    <= is_store;
                    dmem_addr_o  <= {ma_addr_i[31:2], 2'b00};
                    dmem_wmask_o <= is_store ? wmask_d : 4'b0000;
                    dmem_wdata_o <= is_store ? wdata_d : 32'h0;
                    pc_o         <= NOP_PC;
                    ir_o         <= NOP_IR;
                    wb_valid_o   <= 1'b0;
                end else if (mem_op) begin
                    // Misaligned: no bus traffic, instruction retires as a trap.
                    pc_o         <= pc_i;
                    ir_o         <= ir_i;
                    wb_data_o    <= wb_data_i;
                    wb_valid_o   <= 1'b0;
                    trap_o       <= 1'b1;
                    trap_cause_o <= 1'b0;
                end else begin
                    pc_o       <= pc_i;
                    ir_o       <= ir_i;
                    wb_data_o  <= wb_data_i;
                    wb_valid_o <= wb_valid_i;
                end
            end else begin
                if (dmem_ack_i) begin
                    state_q      <= S_IDLE;
                    tmo_cnt_q    <= '0;
                    dmem_req_o   <= 1'b0;
                    dmem_we_o    <= 1'b0;
                    dmem_wmask_o <= 4'b0000;
                    pc_o         <= pc_i;
                    ir_o         <= ir_i;
                    wb_data_o    <= is_load ? ld_data_d : wb_data_i;
                    wb_valid_o   <= wb_valid_i;
                end else if (tmo_fire) begin
                    // Abort: any ack arriving later lands in IDLE and is ignored.
                    state_q      <= S_IDLE;
                    tmo_cnt_q    <= '0;
                    dmem_req_o   <= 1'b0;
                    dmem_we_o    <= 1'b0;
                    dmem_wmask_o <= 4'b0000;
                    pc_o         <= pc_i;
                    ir_o         <= ir_i;
                    wb_data_o    <= wb_data_i;
                    wb_valid_o   <= 1'b0;
                    trap_o       <= 1'b1;
                    trap_cause_o <= 1'b1;
                end else begin
                    tmo_cnt_q  <= tmo_cnt_d;
                    pc_o       <= NOP_PC;
                    ir_o       <= NOP_IR;
                    wb_valid_o <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_ma.sv
// -----------------------------------------------------------------------------
// tb_cpu_ma -- directed and randomized bench for cpu_ma.
// Expected values come from a byte-oriented model of loads/stores
// (lane = byte index, access = n bytes starting at addr % 4).
// -----------------------------------------------------------------------------
module tb_cpu_ma;

    localparam int          TMO          = 4;
    localparam logic [31:0] NOP_PC       = 32'h0000_0000;
    localparam logic [31:0] NOP_IR       = 32'h0000_0013;

    localparam logic [1:0]  MA_X     = 2'd0;
    localparam logic [1:0]  MA_LOAD  = 2'd1;
    localparam logic [1:0]  MA_STORE = 2'd2;
    localparam logic [2:0]  SZ_B  = 3'd0;
    localparam logic [2:0]  SZ_H  = 3'd1;
    localparam logic [2:0]  SZ_W  = 3'd2;
    localparam logic [2:0]  SZ_BU = 3'd4;
    localparam logic [2:0]  SZ_HU = 3'd5;
    localparam logic [1:0]  SRC_ALU = 2'd0;
    localparam logic [1:0]  SRC_MEM = 2'd1;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset_i;
    always #5 clk = ~clk;

    logic [31:0] pc_i, ir_i, ma_addr_i, ma_data_i, wb_data_i;
    logic [1:0]  ma_mode_i, wb_src_i;
    logic [2:0]  ma_size_i;
    logic        wb_valid_i;
    logic        dmem_req_o, dmem_we_o, dmem_ack_i;
    logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
    logic [3:0]  dmem_wmask_o;
    logic [4:0]  wb_addr_async_o;
    logic [31:0] wb_data_async_o;
    logic        wb_ready_async_o, wb_valid_async_o, empty_async_o, stall_async_o;
    logic [31:0] pc_o, ir_o, wb_data_o;
    logic        wb_valid_o, trap_o, trap_cause_o, dbg_state_o;

    cpu_ma #(
        .DMEM_TIMEOUT (TMO),
        .NOP_PC       (NOP_PC),
        .NOP_IR       (NOP_IR),
        .NOP_WB_VALID (1'b0)
    ) dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .pc_i             (pc_i),
        .ir_i             (ir_i),
        .ma_addr_i        (ma_addr_i),
        .ma_mode_i        (ma_mode_i),
        .ma_size_i        (ma_size_i),
        .ma_data_i        (ma_data_i),
        .wb_src_i         (wb_src_i),
        .wb_data_i        (wb_data_i),
        .wb_valid_i       (wb_valid_i),
        .dmem_req_o       (dmem_req_o),
        .dmem_we_o        (dmem_we_o),
        .dmem_addr_o      (dmem_addr_o),
        .dmem_wmask_o     (dmem_wmask_o),
        .dmem_wdata_o     (dmem_wdata_o),
        .dmem_rdata_i     (dmem_rdata_i),
        .dmem_ack_i       (dmem_ack_i),
        .wb_addr_async_o  (wb_addr_async_o),
        .wb_data_async_o  (wb_data_async_o),
        .wb_ready_async_o (wb_ready_async_o),
        .wb_valid_async_o (wb_valid_async_o),
        .empty_async_o    (empty_async_o),
        .stall_async_o    (stall_async_o),
        .pc_o             (pc_o),
        .ir_o             (ir_o),
        .wb_data_o        (wb_data_o),
        .wb_valid_o       (wb_valid_o),
        .trap_o           (trap_o),
        .trap_cause_o     (trap_cause_o),
        .dbg_state_o      (dbg_state_o)
    );

    // ---------------- scoreboard counters / checker ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [2:0] sz);
        case (sz)
            SZ_B, SZ_BU: return 1;
            SZ_H, SZ_HU: return 2;
            default:     return 4;
        endcase
    endfunction

    function automatic logic [3:0] model_mask(input int off, input int n);
        logic [3:0] m;
        for (int i = 0; i < 4; i++) m[i] = (i >= off) && (i < off + n);
        return m;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] d, input int n);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % n) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] rd, input int off,
                                               input logic [2:0] sz);
        int          n;
        logic [31:0] lim;
        logic [31:0] v;
        n   = nbytes(sz);
        lim = (n == 1) ? 32'hFF : (n == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
        v   = (rd >> (8 * off)) & lim;
        if ((sz == SZ_B || sz == SZ_H) && v > (lim >> 1)) v = v | ~lim;
        return v;
    endfunction

    // ---------------- driver ----------------
    // waits = ack-less BUSY cycles before ack; waits >= TMO means timeout.
    task automatic do_op(input string nm, input logic [1:0] mode, input logic [2:0] sz,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [1:0] src, input logic [31:0] wbd, input logic vld,
                         input logic [31:0] pc, input logic [31:0] ir,
                         input int waits, input logic [31:0] rdata);
        int          n, off;
        bit          mem, mis;
        logic [31:0] exp_d;
        @(negedge clk);
        pc_i = pc; ir_i = ir; ma_addr_i = addr; ma_mode_i = mode; ma_size_i = sz;
        ma_data_i = data; wb_src_i = src; wb_data_i = wbd; wb_valid_i = vld;
        dmem_ack_i = 1'b0; dmem_rdata_i = $urandom;
        n   = nbytes(sz);
        off = int'(addr % 4);
        mem = (mode == MA_LOAD) || (mode == MA_STORE);
        mis = mem && ((off % n) != 0);
        #1;
        check({nm, ".empty"},  empty_async_o, pc == NOP_PC);
        check({nm, ".fwdadr"}, wb_addr_async_o, ir[11:7]);
        check({nm, ".fwdvld"}, wb_valid_async_o, vld);
        check({nm, ".ready"},  wb_ready_async_o, src != SRC_MEM);
        check({nm, ".fwddat"}, wb_data_async_o, wbd);
        if (!mem || mis) begin
            check({nm, ".stall"}, stall_async_o, 0);
            @(posedge clk); #1;
            check({nm, ".req"},   dmem_req_o, 0);
            check({nm, ".pc"},    pc_o, pc);
            check({nm, ".ir"},    ir_o, ir);
            check({nm, ".valid"}, wb_valid_o, mis ? 1'b0 : vld);
            check({nm, ".trap"},  trap_o, mis);
            if (mis) check({nm, ".cause"}, trap_cause_o, 0);
            else     check({nm, ".wbdat"}, wb_data_o, wbd);
        end else begin
            check({nm, ".stall0"}, stall_async_o, 1);
            @(posedge clk); #1;
            check({nm, ".req"},   dmem_req_o, 1);
            check({nm, ".we"},    dmem_we_o, mode == MA_STORE);
            check({nm, ".addr"},  dmem_addr_o, addr - off);
            check({nm, ".mask"},  dmem_wmask_o, (mode == MA_STORE) ? model_mask(off, n) : 4'h0);
            check({nm, ".wdata"}, dmem_wdata_o, (mode == MA_STORE) ? model_wdata(data, n) : 32'h0);
            check({nm, ".bubpc"}, pc_o, NOP_PC);
            check({nm, ".bubv"},  wb_valid_o, 0);
            check({nm, ".trap0"}, trap_o, 0);
            for (int k = 0; k <= TMO; k++) begin
                @(negedge clk);
                if (k == waits) begin dmem_ack_i = 1'b1; dmem_rdata_i = rdata; end
                #1;
                check({nm, ".empty_b"}, empty_async_o, 0);
                if (k == waits) begin
                    exp_d = (mode == MA_LOAD) ? model_load(rdata, off, sz) : wbd;
                    check({nm, ".stall_a"}, stall_async_o, 0);
                    check({nm, ".ready_a"}, wb_ready_async_o, 1);
                    check({nm, ".fwd_a"},   wb_data_async_o, exp_d);
                    @(posedge clk); #1;
                    check({nm, ".req_d"},   dmem_req_o, 0);
                    check({nm, ".pc"},      pc_o, pc);
                    check({nm, ".ir"},      ir_o, ir);
                    check({nm, ".valid"},   wb_valid_o, vld);
                    check({nm, ".wbdat"},   wb_data_o, exp_d);
                    check({nm, ".trap"},    trap_o, 0);
                    break;
                end
                check({nm, ".hold"},    dmem_req_o, 1);
                check({nm, ".haddr"},   dmem_addr_o, addr - off);
                check({nm, ".stall_w"}, stall_async_o, (k + 1 == TMO) ? 1'b0 : 1'b1);
                @(posedge clk); #1;
                if (k + 1 == TMO) begin
                    check({nm, ".tmo_req"},   dmem_req_o, 0);
                    check({nm, ".tmo_trap"},  trap_o, 1);
                    check({nm, ".tmo_cause"}, trap_cause_o, 1);
                    check({nm, ".tmo_valid"}, wb_valid_o, 0);
                    break;
                end
                check({nm, ".trap_w"}, trap_o, 0);
                check({nm, ".bubv_w"}, wb_valid_o, 0);
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [1:0]  r_mode;
        logic [2:0]  r_sz;
        logic [1:0]  r_src;
        logic [31:0] r_pc;
        int          r_pick;

        reset_i = 1'b1;
        pc_i = NOP_PC; ir_i = NOP_IR; ma_addr_i = '0; ma_mode_i = MA_X; ma_size_i = SZ_W;
        ma_data_i = '0; wb_src_i = SRC_ALU; wb_data_i = '0; wb_valid_i = 1'b0;
        dmem_ack_i = 1'b0; dmem_rdata_i = '0;
        #2;
        check("rst.pc",    pc_o, NOP_PC);
        check("rst.ir",    ir_o, NOP_IR);
        check("rst.wbdat", wb_data_o, 0);
        check("rst.valid", wb_valid_o, 0);
        check("rst.req",   dmem_req_o, 0);
        check("rst.mask",  dmem_wmask_o, 0);
        check("rst.addr",  dmem_addr_o, 0);
        check("rst.trap",  trap_o, 0);
        check("rst.state", dbg_state_o, 0);
        @(negedge clk);
        reset_i = 1'b0;

        // Directed cases
        do_op("alu", MA_X, SZ_W, 32'h0, 32'h0, SRC_ALU, 32'h1234, 1'b1,
              32'h100, 32'h0000_0533, 0, 32'h0);
        do_op("lb", MA_LOAD, SZ_B, 32'h1003, 32'h0, SRC_MEM, 32'h0, 1'b1,
              32'h104, 32'h0031_8283, 3, 32'h80FF_FF00);
        check("lb.const", wb_data_o, 32'hFFFF_FF80);
        do_op("lbu", MA_LOAD, SZ_BU, 32'h1003, 32'h0, SRC_MEM, 32'h0, 1'b1,
              32'h108, 32'h0031_C283, 3, 32'h80FF_FF00);
        check("lbu.const", wb_data_o, 32'h0000_0080);
        do_op("sh", MA_STORE, SZ_H, 32'h2002, 32'hABCD_BEEF, SRC_ALU, 32'h0, 1'b0,
              32'h10C, 32'h0051_1123, 0, 32'h0);
        do_op("lw_mis", MA_LOAD, SZ_W, 32'h3001, 32'h0, SRC_MEM, 32'h0, 1'b1,
              32'h110, 32'h0001_A303, 0, 32'h0);
        do_op("lw_tmo", MA_LOAD, SZ_W, 32'h3004, 32'h0, SRC_MEM, 32'h0, 1'b1,
              32'h114, 32'h0041_A383, TMO + 2, 32'h0);

        // Stray ack while IDLE after the abort
        @(negedge clk);
        ma_mode_i = MA_X; wb_src_i = SRC_ALU; wb_data_i = 32'h5555_AAAA; wb_valid_i = 1'b1;
        pc_i = 32'h118; ir_i = 32'h0000_0013; dmem_ack_i = 1'b1; dmem_rdata_i = 32'hDEAD_BEEF;
        #1;
        check("stray.stall", stall_async_o, 0);
        check("stray.fwd",   wb_data_async_o, 32'h5555_AAAA);
        @(posedge clk); #1;
        check("stray.req",   dmem_req_o, 0);
        check("stray.wbdat", wb_data_o, 32'h5555_AAAA);
        check("stray.trap",  trap_o, 0);
        check("stray.state", dbg_state_o, 0);

        // Reset during BUSY
        @(negedge clk);
        dmem_ack_i = 1'b0; ma_mode_i = MA_LOAD; ma_size_i = SZ_W; ma_addr_i = 32'h4000;
        wb_src_i = SRC_MEM; pc_i = 32'h11C;
        @(posedge clk); #1;
        check("rb.req1", dmem_req_o, 1);
        #2 reset_i = 1'b1;
        #1;
        check("rb.req0", dmem_req_o, 0);
        check("rb.pc",   pc_o, NOP_PC);
        check("rb.st",   dbg_state_o, 0);
        @(negedge clk);
        ma_mode_i = MA_X;
        reset_i = 1'b0;
        do_op("rb_alu", MA_X, SZ_W, 32'h0, 32'h0, SRC_ALU, 32'h0BAD_F00D, 1'b1,
              32'h120, 32'h0000_0B33, 0, 32'h0);

        // Randomized
        for (int t = 0; t < 200; t++) begin
            r_pick = $urandom_range(0, 9);
            r_mode = (r_pick < 3) ? MA_X : (r_pick < 7) ? MA_LOAD : MA_STORE;
            if (r_mode == MA_LOAD) begin
                case ($urandom_range(0, 4))
                    0: r_sz = SZ_B;  1: r_sz = SZ_H;  2: r_sz = SZ_W;
                    3: r_sz = SZ_BU; default: r_sz = SZ_HU;
                endcase
                r_src = SRC_MEM;
            end else begin
                case ($urandom_range(0, 2))
                    0: r_sz = SZ_B; 1: r_sz = SZ_H; default: r_sz = SZ_W;
                endcase
                r_src = ($urandom_range(0, 1) == 0) ? SRC_ALU : 2'($urandom_range(2, 3));
            end
            r_pc = ($urandom_range(0, 7) == 0) ? NOP_PC : $urandom;
            do_op("rnd", r_mode, r_sz, $urandom, $urandom, r_src, $urandom,
                  1'($urandom_range(0, 1)), r_pc, $urandom,
                  $urandom_range(0, TMO + 1), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cpu_ma.md
Name: cpu_ma

Overview:
- Risc-V CPU memory-access stage; consumes the EX→MA pipeline register (pc, ir, ma_addr/mode/size/data, wb_src/data/valid).
- Performs loads and stores over a req/ack data-memory port: byte lanes, sign extension, misalignment detection, optional timeout.
- Provides async forwarding and a stall back to upstream stages, and registers results toward WB.

Parameters:
- DMEM_TIMEOUT, 0, cycles to wait in BUSY for dmem_ack_i before abort; 0 disables the timeout.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous active-high reset
- pc_i, ir_i  in  32,32  program counter / instruction from EX
- ma_addr_i  in  32  byte address
- ma_mode_i  in  ma_mode_t  MA_X / MA_LOAD / MA_STORE
- ma_size_i  in  ma_size_t  B, H, W, BU, HU
- ma_data_i  in  32  store data
- wb_src_i  in  wb_src_t  write-back source
- wb_data_i  in  32  non-memory write-back data
- wb_valid_i  in  1  write-back valid
- dmem_req_o  out  1  access request (registered)
- dmem_we_o  out  1  1 = store
- dmem_addr_o  out  32  word address: {ma_addr[31:2], 2'b00}
- dmem_wmask_o  out  4  byte-lane write enables
- dmem_wdata_o  out  32  lane-replicated store data
- dmem_rdata_i  in  32  read word, valid with ack
- dmem_ack_i  in  1  access complete
- wb_addr_async_o  out  5  ir_i[11:7]
- wb_data_async_o  out  32  forwarded data
- wb_ready_async_o  out  1  forwarded data final
- wb_valid_async_o  out  1  wb_valid_i
- empty_async_o  out  1  pc_i == NOP_PC and state IDLE
- stall_async_o  out  1  hold upstream inputs stable
- pc_o, ir_o, wb_data_o  out  32 each  to WB
- wb_valid_o  out  1  to WB
- trap_o  out  1  one-cycle pulse: misaligned access or timeout
- trap_cause_o  out  1  0 = misaligned, 1 = bus timeout

Behaviour:
- Reset (async, immediate):
  - state = IDLE; dmem_req_o/we/wmask = 0; dmem_addr/wdata = 0.
  - pc_o = NOP_PC, ir_o = NOP_IR, wb_data_o = 0, wb_valid_o = NOP_WB_VALID, trap_o = 0, timeout counter = 0.
- Misaligned: H/HU with addr[0] = 1, or W with addr[1:0] ≠ 0.
- No memory op (ma_mode_i == MA_X):
  - stall_async_o = 0; pass-through, 1-cycle latency.
  - wb_data_o <= wb_data_i.
- IDLE, aligned memory op:
  - stall_async_o = 1.
  - Next edge: state <= BUSY, dmem_req_o <= 1, address/we/mask/wdata registered.
  - Outputs <= bubble (NOP_PC, NOP_IR, wb_valid 0).
- IDLE, misaligned op:
  - No request; stall 0.
  - Next edge: pc_o/ir_o pass, wb_valid_o <= 0, trap_o <= 1, trap_cause_o <= 0.
- BUSY:
  - dmem_req/addr/we/wmask/wdata held stable until ack.
  - stall_async_o = !dmem_ack_i.
  - On ack: pc_o/ir_o/wb_valid_o <= inputs; wb_data_o <= formatted load (stores: wb_data_i); state <= IDLE; dmem_req_o <= 0.
  - Minimum memory-op latency: 2 cycles.
- Timeout: counter increments each BUSY cycle without ack. When count reaches DMEM_TIMEOUT (≠0):
  - Abort: req <= 0, state <= IDLE.
  - trap_o <= 1, trap_cause_o <= 1, wb_valid_o <= 0.
  - A late ack is ignored.
- dmem_ack_i in IDLE: ignored.
- Store lanes:
  - B: wmask = 0001 << addr[1:0], wdata = {4{data[7:0]}}.
  - H: wmask = 0011 << addr[1:0], wdata = {2{data[15:0]}}.
  - W: wmask = 1111, wdata = data.
- Load format: select byte/half by addr[1:0]. B/H sign-extend; BU/HU zero-extend; W raw.
- Forwarding:
  - wb_data_async_o = formatted rdata when BUSY && ack && load, else wb_data_i.
  - wb_ready_async_o = (wb_src_i != WB_SRC_MEM) || (BUSY && dmem_ack_i).
- Reset mid-BUSY: request dropped same instant. The memory must discard the abandoned request and issue no ack.

Test Plan:
- ALU op: wb_src ALU, wb_data_i = 0x1234 -> next cycle wb_data_o = 0x1234, no dmem_req_o, stall 0.
- LB addr 0x1003, ack after 3 cycles with rdata 0x80FF_FF00 -> dmem_addr 0x1000, stall held 4 cycles, wb_data_o = 0xFFFF_FF80. LBU on same inputs -> 0x0000_0080.
- SH addr 0x2002, data 0xABCD_BEEF, zero-wait ack -> wmask 1100, wdata 0xBEEF_BEEF, we 1, latency 2 cycles.
- LW addr 0x3001 -> no req, trap_o pulse with cause 0, wb_valid_o 0, stall 0.
- DMEM_TIMEOUT = 4, LW with no ack -> req dropped after 4 BUSY cycles, trap cause 1; a later stray ack has no effect.
- Assert reset_i during BUSY -> dmem_req_o falls without waiting for clock. After release, an ALU op passes normally.
